// File: rtl/blinkled_cascade_if.sv
// blinkled_cascade_if: period-write handshake between a configuring master and the blinker
interface blinkled_cascade_if #(
    parameter int CH_BITS   = 2,
    parameter int CNT_WIDTH = 32
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_BITS-1:0]   cfg_ch;
    logic [CNT_WIDTH-1:0] cfg_period;
    modport master (output cfg_valid, cfg_ch, cfg_period, input cfg_ready);
    modport slave (input cfg_valid, cfg_ch, cfg_period, output cfg_ready);
endinterface

// File: rtl/blinkled_cascade.sv
// blinkled_cascade: multi-channel runtime-programmable LED blinker
// Define BLINKLED_CASCADE_EN to make channel i count the ticks of channel i-1.
module blinkled_cascade #(
    parameter int WIDTH          = 8,
    parameter int NUM_CH         = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int DEFAULT_PERIOD = 1023,
    parameter int CH_BITS        = (NUM_CH > 1 ? $clog2(NUM_CH) : 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    blinkled_cascade_if.slave       cfg,
    input  logic [NUM_CH-1:0]       enable,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH*WIDTH-1:0] LED
);
    logic ready_q, ready_d, acc;
    always_comb begin
        acc     = cfg.cfg_valid && ready_q;
        ready_d = !acc;
    end
    always_ff @(posedge CLK) begin
        ready_q <= RST ? 1'b1 : ready_d;
    end
    assign cfg.cfg_ready = ready_q;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] period_q, period_d, cnt_q, cnt_d;
        logic [WIDTH-1:0]     led_q, led_d;
        logic                 tick_q, tick_d, ev, wr, wrap;
`ifdef BLINKLED_CASCADE_EN
        if (i > 0) begin : g_casc
            assign ev = tick[i-1];
        end else begin : g_first
            assign ev = 1'b1;
        end
`else
        assign ev = 1'b1;
`endif
        // A write clears the count, so a shrunk period never causes a long wrap.
        always_comb begin
            wr       = acc && (cfg.cfg_ch == CH_BITS'(i));
            wrap     = cnt_q == period_q;
            period_d = wr ? cfg.cfg_period : period_q;
            cnt_d    = wr ? '0 : (enable[i] && ev) ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
            tick_d   = !wr && enable[i] && ev && wrap;
            led_d    = (tick_q && enable[i]) ? led_q + 1'b1 : led_q;
        end
        always_ff @(posedge CLK) begin
            if (RST) begin
                period_q <= CNT_WIDTH'(DEFAULT_PERIOD);
                cnt_q    <= '0;
                tick_q   <= 1'b0;
                led_q    <= '0;
            end else begin
                period_q <= period_d;
                cnt_q    <= cnt_d;
                tick_q   <= tick_d;
                led_q    <= led_d;
            end
        end
        assign tick[i]              = tick_q;
        assign LED[i*WIDTH +: WIDTH] = led_q;
    end
endmodule
